peripheral_interrupt_controller: RTL and testbench
==================================================

PERIPHERAL_INTERRUPT_CONTROLLER -- requirements
Module: peripheral_interrupt_controller

Interface
REQ-001 Parameter NUM_BANKS, default 1: number of 8-bit PIR/PIE bank pairs, legal range 1..4; N = 8*NUM_BANKS channels.
REQ-002 Parameter STROBE_MASK, default {NUM_BANKS{8'b11001111}}: bit i = 1 makes channel i strobe-type (sticky flag), bit i = 0 makes it readonly/level-type.
REQ-003 Parameter ACK_CLEARS, default 1'b1: if 1, an ack clears the flag of the acknowledged strobe-type channel.
REQ-004 clk  in  1  core clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 irq_strobes  in  N  per-channel one-cycle set pulses (strobe-type channels only).
REQ-007 irq_readonlys  in  N  per-channel level inputs (level-type channels only).
REQ-008 bank_sel  in  max(1,clog2(NUM_BANKS))  selects the bank for register reads and writes.
REQ-009 pir_wr_en / pie_wr_en  in  1 each  write wr_data into the selected PIR / PIE bank.
REQ-010 wr_data  in  8  register write data.
REQ-011 rd_pie  in  1  0 = rd_data shows the selected PIR bank, 1 = the selected PIE bank.
REQ-012 rd_data  out  8  combinational read of the selected register.
REQ-013 peie  in  1  peripheral interrupt global enable.
REQ-014 ack  in  1  one-cycle acknowledge of the currently presented irq_id.
REQ-015 irq_pending  out  1  registered: some channel is flagged, enabled, and peie=1.
REQ-016 irq_id  out  clog2(N) (min 1)  registered index of the lowest-numbered pending channel.
REQ-017 irq_any_flag  out  1  registered: some channel is flagged AND enabled, regardless of peie (sleep wake-up).

Function
REQ-018 Strobe-type flag i SHALL be set on the clk edge after irq_strobes[i]=1 and SHALL hold until cleared by software write or ack.
REQ-019 Level-type flag i SHALL equal irq_readonlys[i] registered by one cycle; software writes to that bit SHALL be ignored.
REQ-020 A PIR write SHALL load wr_data into the strobe-type bits of the selected bank only.
REQ-021 If a strobe and a clearing write (or ack) hit the same bit in the same cycle, the strobe SHALL win and the bit SHALL be 1.
REQ-022 A PIE write SHALL load all 8 bits of the selected bank; PIE SHALL hold otherwise.
REQ-023 bank_sel >= NUM_BANKS SHALL make writes no-ops and SHALL make rd_data read 8'h00.
REQ-024 irq_pending, irq_id and irq_any_flag SHALL be computed from the current flag, PIE and peie values and registered, so irq_pending rises 2 cycles after a strobe on an enabled channel.
REQ-025 irq_id SHALL use fixed priority with the lowest index highest, and SHALL be 0 when nothing is pending.
REQ-026 ack with ACK_CLEARS=1 and irq_pending=1 SHALL clear the flag at irq_id if that channel is strobe-type; otherwise ack SHALL have no effect.
REQ-027 ack when irq_pending=0 SHALL be ignored.
REQ-028 After a clear, irq_pending and irq_id SHALL update on the following cycle to the next pending channel, if any.

Reset
REQ-029 rst=1 SHALL clear all PIR strobe bits, all PIE bits, the level-flag registers, irq_pending, irq_any_flag and irq_id (all to 0), taking priority over every other input in that cycle.
REQ-030 A strobe asserted in the same cycle as rst SHALL be lost.

Structure
REQ-031 Shared package SHALL hold BANK_WIDTH=8, MAX_BANKS=4, and a clog2-based width function for irq_id and bank_sel.
REQ-032 A sub-module priority_encoder (parametrised width, outputs index and valid) SHALL implement REQ-025.

Verification
REQ-033 NUM_BANKS=1, PIE=8'h01, peie=1, strobe on ch0 at cycle t -> PIR=8'h01 at t+1, irq_pending=1 and irq_id=0 at t+2.
REQ-034 Strobe on ch3 and a PIR write of 8'h00 in the same cycle -> PIR bit3=1 afterwards.
REQ-035 NUM_BANKS=2, PIE bank1=8'hFF, strobes on ch9 and ch12 together -> irq_id=9; ack -> irq_id=12 two cycles later; ack -> irq_pending=0.
REQ-036 Level ch4 held high, PIR write 8'h00 -> bit4 stays 1; level low -> bit4=0 one cycle later.
REQ-037 peie=0 with ch1 flagged and enabled -> irq_pending=0, irq_any_flag=1.
REQ-038 rst asserted with flags pending -> next cycle all outputs 0, rd_data=8'h00 for PIR and PIE.

Source files
------------

// File: rtl/peripheral_interrupt_controller_pkg.sv
// Shared constants and width helper for the peripheral interrupt controller.
package peripheral_interrupt_controller_pkg;

  localparam int unsigned BANK_WIDTH = 8;
  localparam int unsigned MAX_BANKS  = 4;

  // Bits needed to index n items, never less than one.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/peripheral_interrupt_controller_priority_encoder.sv
// Fixed-priority encoder: lowest set request index wins.
module priority_encoder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Scan from the top so the lowest set bit is the last assignment.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/peripheral_interrupt_controller.sv
// Banked PIR/PIE interrupt controller with sticky strobe flags, level flags,
// global enable and prioritised, acknowledgeable interrupt presentation.
module peripheral_interrupt_controller
  import peripheral_interrupt_controller_pkg::*;
#(
  parameter int unsigned                        NUM_BANKS   = 1,
  parameter logic [BANK_WIDTH*NUM_BANKS-1:0]    STROBE_MASK = {NUM_BANKS{8'b11001111}},
  parameter bit                                 ACK_CLEARS  = 1'b1,
  localparam int unsigned                       N           = BANK_WIDTH * NUM_BANKS,
  localparam int unsigned                       IDW         = idx_width(N),
  localparam int unsigned                       BSW         = idx_width(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          irq_strobes,
  input  logic [N-1:0]          irq_readonlys,
  input  logic [BSW-1:0]        bank_sel,
  input  logic                  pir_wr_en,
  input  logic                  pie_wr_en,
  input  logic [BANK_WIDTH-1:0] wr_data,
  input  logic                  rd_pie,
  output logic [BANK_WIDTH-1:0] rd_data,
  input  logic                  peie,
  input  logic                  ack,
  output logic                  irq_pending,
  output logic [IDW-1:0]        irq_id,
  output logic                  irq_any_flag
);

  logic [N-1:0]   flag_q, flag_d;
  logic [N-1:0]   pie_q, pie_d;
  logic [N-1:0]   ack_clr;
  logic [N-1:0]   active;
  logic           irq_pending_q, irq_pending_d;
  logic           irq_any_flag_q, irq_any_flag_d;
  logic [IDW-1:0] irq_id_q, irq_id_d;
  logic [IDW-1:0] enc_idx;
  logic           enc_valid;
  logic           bank_ok;

  assign bank_ok = 32'(bank_sel) < NUM_BANKS;

  // Flag and enable next state: write, then ack clear, then strobes win; level bits track inputs.
  always_comb begin
    flag_d  = flag_q;
    pie_d   = pie_q;
    ack_clr = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (bank_ok && (bank_sel == BSW'(b))) begin
        if (pir_wr_en) flag_d[b*BANK_WIDTH +: BANK_WIDTH] = wr_data;
        if (pie_wr_en) pie_d[b*BANK_WIDTH +: BANK_WIDTH]  = wr_data;
      end
    end
    if (ACK_CLEARS && ack && irq_pending_q) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (irq_id_q == IDW'(i)) ack_clr[i] = 1'b1;
      end
    end
    flag_d = flag_d & ~ack_clr;
    flag_d = ((flag_d | irq_strobes) & STROBE_MASK) | (irq_readonlys & ~STROBE_MASK);
  end

  // Combinational register read of the selected bank.
  always_comb begin
    rd_data = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (bank_ok && (bank_sel == BSW'(b))) begin
        rd_data = rd_pie ? pie_q[b*BANK_WIDTH +: BANK_WIDTH]
                         : flag_q[b*BANK_WIDTH +: BANK_WIDTH];
      end
    end
  end

  assign active = flag_q & pie_q;

  priority_encoder #(
    .WIDTH (N),
    .IDX_W (IDW)
  ) u_prio (
    .req_i   (active),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  always_comb begin
    irq_any_flag_d = enc_valid;
    irq_pending_d  = enc_valid & peie;
    irq_id_d       = irq_pending_d ? enc_idx : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q         <= '0;
      pie_q          <= '0;
      irq_pending_q  <= 1'b0;
      irq_any_flag_q <= 1'b0;
      irq_id_q       <= '0;
    end else begin
      flag_q         <= flag_d;
      pie_q          <= pie_d;
      irq_pending_q  <= irq_pending_d;
      irq_any_flag_q <= irq_any_flag_d;
      irq_id_q       <= irq_id_d;
    end
  end

  assign irq_pending  = irq_pending_q;
  assign irq_id       = irq_id_q;
  assign irq_any_flag = irq_any_flag_q;

endmodule

// File: tb/tb_peripheral_interrupt_controller.sv
// Directed bench: one single-bank instance with default masks, one two-bank
// instance with bank 1 fully strobe-type.
module tb_peripheral_interrupt_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Single-bank instance (default parameters)
  logic [7:0] a_strobes, a_levels, a_wdata, a_rdata;
  logic [0:0] a_bank_sel;
  logic       a_pir_we, a_pie_we, a_rd_pie, a_peie, a_ack, a_pend, a_any;
  logic [2:0] a_id;

  // Two-bank instance
  logic [15:0] b_strobes, b_levels;
  logic [7:0]  b_wdata, b_rdata;
  logic [0:0]  b_bank_sel;
  logic        b_pir_we, b_pie_we, b_rd_pie, b_peie, b_ack, b_pend, b_any;
  logic [3:0]  b_id;

  int n_cmp = 0;
  int n_err = 0;

  peripheral_interrupt_controller u_dut_a (
    .clk           (clk),
    .rst           (rst),
    .irq_strobes   (a_strobes),
    .irq_readonlys (a_levels),
    .bank_sel      (a_bank_sel),
    .pir_wr_en     (a_pir_we),
    .pie_wr_en     (a_pie_we),
    .wr_data       (a_wdata),
    .rd_pie        (a_rd_pie),
    .rd_data       (a_rdata),
    .peie          (a_peie),
    .ack           (a_ack),
    .irq_pending   (a_pend),
    .irq_id        (a_id),
    .irq_any_flag  (a_any)
  );

  peripheral_interrupt_controller #(
    .NUM_BANKS   (2),
    .STROBE_MASK (16'hFFCF),
    .ACK_CLEARS  (1'b1)
  ) u_dut_b (
    .clk           (clk),
    .rst           (rst),
    .irq_strobes   (b_strobes),
    .irq_readonlys (b_levels),
    .bank_sel      (b_bank_sel),
    .pir_wr_en     (b_pir_we),
    .pie_wr_en     (b_pie_we),
    .wr_data       (b_wdata),
    .rd_pie        (b_rd_pie),
    .rd_data       (b_rdata),
    .peie          (b_peie),
    .ack           (b_ack),
    .irq_pending   (b_pend),
    .irq_id        (b_id),
    .irq_any_flag  (b_any)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    a_strobes = 8'h01; a_levels = '0; a_wdata = '0; a_bank_sel = '0;
    a_pir_we = 1'b0; a_pie_we = 1'b0; a_rd_pie = 1'b0; a_peie = 1'b0; a_ack = 1'b0;
    b_strobes = 16'h0200; b_levels = '0; b_wdata = '0; b_bank_sel = '0;
    b_pir_we = 1'b0; b_pie_we = 1'b0; b_rd_pie = 1'b0; b_peie = 1'b0; b_ack = 1'b0;

    // Reset with strobes asserted: strobes lost, everything zero
    tick();
    rst = 1'b0; a_strobes = '0; b_strobes = '0;
    check("rst_pir_a", 32'(a_rdata), 32'h00);
    check("rst_pend_a", 32'(a_pend), 32'h0);
    check("rst_id_a", 32'(a_id), 32'h0);
    check("rst_any_a", 32'(a_any), 32'h0);
    b_bank_sel = 1'b1;
    #1 check("rst_pir_b1", 32'(b_rdata), 32'h00);
    a_rd_pie = 1'b1;
    #1 check("rst_pie_a", 32'(a_rdata), 32'h00);
    a_rd_pie = 1'b0;

    // Two banks: ch9 and ch12 together, then ack twice
    b_pie_we = 1'b1; b_wdata = 8'hFF; b_peie = 1'b1;
    tick();
    b_pie_we = 1'b0; b_strobes = 16'h1200;
    tick();
    b_strobes = '0;
    check("b_pir_bank1", 32'(b_rdata), 32'h12);
    tick();
    check("b_pend_first", 32'(b_pend), 32'h1);
    check("b_id_first", 32'(b_id), 32'd9);
    b_ack = 1'b1;
    tick();
    b_ack = 1'b0;
    check("b_id_hold", 32'(b_id), 32'd9);
    tick();
    check("b_id_second", 32'(b_id), 32'd12);
    check("b_pend_second", 32'(b_pend), 32'h1);
    b_ack = 1'b1;
    tick();
    b_ack = 1'b0;
    tick();
    check("b_pend_done", 32'(b_pend), 32'h0);
    check("b_id_done", 32'(b_id), 32'h0);
    check("b_pir_bank1_clr", 32'(b_rdata), 32'h00);
    b_bank_sel = 1'b0; b_rd_pie = 1'b1;
    #1 check("b_pie_bank0", 32'(b_rdata), 32'h00);

    // Single bank: enable ch0, strobe, observe latency, ack clears
    a_pie_we = 1'b1; a_wdata = 8'h01; a_peie = 1'b1;
    tick();
    a_pie_we = 1'b0; a_rd_pie = 1'b1;
    #1 check("a_pie_wr", 32'(a_rdata), 32'h01);
    a_rd_pie = 1'b0;
    a_strobes = 8'h01;
    tick();
    a_strobes = '0;
    check("a_s0_pir_t1", 32'(a_rdata), 32'h01);
    check("a_s0_pend_t1", 32'(a_pend), 32'h0);
    tick();
    check("a_s0_pend_t2", 32'(a_pend), 32'h1);
    check("a_s0_id_t2", 32'(a_id), 32'h0);
    check("a_s0_any_t2", 32'(a_any), 32'h1);
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    check("a_ack_pir", 32'(a_rdata), 32'h00);
    check("a_ack_pend_hold", 32'(a_pend), 32'h1);
    tick();
    check("a_ack_pend_clr", 32'(a_pend), 32'h0);

    // Strobe beats a clearing write on the same bit
    a_strobes = 8'h08; a_pir_we = 1'b1; a_wdata = 8'h00;
    tick();
    a_strobes = '0; a_pir_we = 1'b0;
    check("a_strobe_wins", 32'(a_rdata), 32'h08);
    a_pir_we = 1'b1; a_wdata = 8'hFF;
    tick();
    check("a_pir_wr_ff", 32'(a_rdata), 32'hCF);
    a_wdata = 8'h00;
    tick();
    a_pir_we = 1'b0;
    check("a_pir_wr_00", 32'(a_rdata), 32'h00);

    // Level channel ignores writes and follows its input
    a_levels = 8'h10; a_pir_we = 1'b1; a_wdata = 8'h00;
    tick();
    check("a_lvl_set", 32'(a_rdata), 32'h10);
    tick();
    a_pir_we = 1'b0;
    check("a_lvl_wr_ignored", 32'(a_rdata), 32'h10);
    a_levels = 8'h00;
    tick();
    check("a_lvl_fall", 32'(a_rdata), 32'h00);

    // Ack on a level channel has no effect
    a_levels = 8'h10; a_pie_we = 1'b1; a_wdata = 8'h10;
    tick();
    a_pie_we = 1'b0;
    tick();
    check("a_lvl_pend", 32'(a_pend), 32'h1);
    check("a_lvl_id", 32'(a_id), 32'd4);
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    tick();
    check("a_lvl_ack_pend", 32'(a_pend), 32'h1);
    check("a_lvl_ack_pir", 32'(a_rdata), 32'h10);
    a_levels = 8'h00;
    tick();
    tick();
    check("a_lvl_pend_clr", 32'(a_pend), 32'h0);

    // Global enable off: wake-up flag only
    a_pie_we = 1'b1; a_wdata = 8'h02; a_peie = 1'b0; a_strobes = 8'h02;
    tick();
    a_pie_we = 1'b0; a_strobes = '0;
    tick();
    check("a_peie0_pend", 32'(a_pend), 32'h0);
    check("a_peie0_any", 32'(a_any), 32'h1);
    check("a_peie0_id", 32'(a_id), 32'h0);
    a_peie = 1'b1;
    tick();
    check("a_peie1_pend", 32'(a_pend), 32'h1);
    check("a_peie1_id", 32'(a_id), 32'd1);

    // Out-of-range bank: writes dropped, reads zero
    a_bank_sel = 1'b1; a_pir_we = 1'b1; a_pie_we = 1'b1; a_wdata = 8'h00;
    #1 check("a_oob_rd", 32'(a_rdata), 32'h00);
    tick();
    a_pir_we = 1'b0; a_pie_we = 1'b0; a_bank_sel = 1'b0;
    #1 check("a_oob_pir_kept", 32'(a_rdata), 32'h02);
    a_rd_pie = 1'b1;
    #1 check("a_oob_pie_kept", 32'(a_rdata), 32'h02);
    a_rd_pie = 1'b0;

    // Reset with a pending interrupt
    rst = 1'b1;
    tick();
    check("a_rst2_pend", 32'(a_pend), 32'h0);
    check("a_rst2_id", 32'(a_id), 32'h0);
    check("a_rst2_any", 32'(a_any), 32'h0);
    check("a_rst2_pir", 32'(a_rdata), 32'h00);
    a_rd_pie = 1'b1;
    #1 check("a_rst2_pie", 32'(a_rdata), 32'h00);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
